// File: rtl/demux4_1_tdm.sv
// ---------------------------------------------------------------------------
// demux4_1_tdm
//
// Registered 1-to-4 demultiplexer. It is the receive-side partner of a 4:1
// mux and fans a serialised word stream back out into four parallel channel
// registers.
//
// Each valid beat writes DIN into exactly one channel register. The target is
// chosen in one of two ways:
//   - Select mode (MODE=0): the target comes from {S1,S2}.
//   - TDM mode (MODE=1): the target comes from an internal slot counter.
//     FS (frame sync) forces the target back to slot 0.
//
// Ports
//   CLK    : system clock; all state updates on the rising edge
//   RST    : asynchronous reset, active-high
//   DIN    : input data word (WIDTH bits)
//   VALID  : DIN qualifier; nothing is captured when low
//   MODE   : 0 = select by {S1,S2}, 1 = TDM slot counter
//   S1,S2  : channel select (MSB, LSB); used only in select mode
//   FS     : frame sync; forces slot 0; used only in TDM mode with VALID
//   A..D   : channel 0..3 registers
//   STB    : per-channel write strobe, bit i = channel i written (bit 0 = A)
//   FRAME  : one-cycle pulse when channel D is written in TDM mode
//   SLOT   : current slot counter (next TDM target)
//   ERR    : sticky frame-misalignment flag, cleared only by RST
// ---------------------------------------------------------------------------
module demux4_1_tdm #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             VALID,
    input  logic             MODE,
    input  logic             S1,
    input  logic             S2,
    input  logic             FS,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       STB,
    output logic             FRAME,
    output logic [1:0]       SLOT,
    output logic             ERR
);

    logic [1:0]            idx;
    logic [3:0]            stb_d,   stb_q;
    logic                  frame_d, frame_q;
    logic [1:0]            slot_d,  slot_q;
    logic                  err_d,   err_q;
    logic [3:0][WIDTH-1:0] ch_out;

    // Target channel and the next state of the control registers.
    always_comb begin
        idx     = 2'd0;
        stb_d   = 4'b0000;
        frame_d = 1'b0;
        slot_d  = slot_q;
        err_d   = err_q;

        if (MODE) begin
            // Frame sync realigns to slot 0 within the same beat.
            idx = FS ? 2'd0 : slot_q;
        end else begin
            idx = {S1, S2};
        end

        if (VALID) begin
            stb_d = 4'b0001 << idx;
        end

        if (MODE) begin
            if (VALID) begin
                // Modulo-4 wrap comes from the 2-bit width.
                slot_d  = idx + 2'd1;
                frame_d = (idx == 2'd3);
                // Sync arriving anywhere other than slot 0 means the
                // transmitter and receiver disagreed about frame position.
                if (FS && (slot_q != 2'd0)) begin
                    err_d = 1'b1;
                end
            end
        end else begin
            // Select mode discards any partial TDM position, so the first
            // TDM beat afterwards always lands in A.
            slot_d = 2'd0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stb_q   <= 4'b0000;
            frame_q <= 1'b0;
            slot_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            stb_q   <= stb_d;
            frame_q <= frame_d;
            slot_q  <= slot_d;
            err_q   <= err_d;
        end
    end

    // One register per channel. The channel loads DIN only on the beat
    // whose strobe selects it, and holds its value otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic [WIDTH-1:0] ch_d;
            logic [WIDTH-1:0] ch_q;

            always_comb begin
                ch_d = ch_q;
                if (stb_d[gi]) begin
                    ch_d = DIN;
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    ch_q <= '0;
                end else begin
                    ch_q <= ch_d;
                end
            end

            assign ch_out[gi] = ch_q;
        end
    endgenerate

    assign A     = ch_out[0];
    assign B     = ch_out[1];
    assign C     = ch_out[2];
    assign D     = ch_out[3];
    assign STB   = stb_q;
    assign FRAME = frame_q;
    assign SLOT  = slot_q;
    assign ERR   = err_q;

endmodule

// File: doc/demux4_1_tdm.md
Name: demux4_1_tdm

Overview:
- Registered 1-to-4 demultiplexer: the receive-side inverse of the 4:1 mux.
- Routes one input word to one of four output registers A/B/C/D.
- Routing is either by explicit select (S1,S2) or by an internal time-division slot counter with frame sync.
- Used to fan a mux-serialised stream back out into four parallel channels.

Parameters:
- WIDTH, 1, bit width of DIN and of each output word A/B/C/D.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous reset, active-high.
- DIN  in  WIDTH  input data word.
- VALID  in  1  DIN qualifier; nothing is captured when 0.
- MODE  in  1  0 = select mode (S1,S2), 1 = TDM mode (internal slot counter).
- S1  in  1  select MSB; used only in MODE=0.
- S2  in  1  select LSB; used only in MODE=0.
- FS  in  1  frame sync; forces slot 0; used only in MODE=1 together with VALID.
- A  out  WIDTH  channel 0 register.
- B  out  WIDTH  channel 1 register.
- C  out  WIDTH  channel 2 register.
- D  out  WIDTH  channel 3 register.
- STB  out  4  per-channel write strobe; bit i = channel i written this cycle (bit 0 = A).
- FRAME  out  1  one-cycle pulse when channel D is written in MODE=1.
- SLOT  out  2  current slot counter value (next TDM target).
- ERR  out  1  sticky frame-misalignment flag.

Behaviour:
- Reset: one clock, CLK. RST asynchronous, active-high. While RST=1: A=B=C=D=0, STB=0000, FRAME=0, SLOT=00, ERR=0. After deassertion, the first rising edge is a normal cycle.
- Latency: one cycle. Data sampled on edge k appears on the target output and on STB after edge k. STB and FRAME are registered and high for exactly one cycle per write.
- Index mapping: idx 0→A, 1→B, 2→C, 3→D, matching the mux selection {S1,S2}=00→A … 11→D.
- VALID=0: A–D hold their values, STB=0000, FRAME=0. SLOT holds in MODE=1 and clears to 00 in MODE=0. ERR holds. FS is ignored.
- MODE=0, VALID=1:
  - idx={S1,S2}; output[idx]<=DIN; STB<=one-hot(idx).
  - FRAME=0; FS ignored; ERR unchanged; SLOT forced to 00.
- MODE=1, VALID=1:
  - idx = FS ? 00 : SLOT; output[idx]<=DIN; STB<=one-hot(idx).
  - SLOT<=(idx+1) mod 4, wrapping 11→00.
  - FRAME<=1 iff idx==3.
  - FS=1 with SLOT!=00 sets ERR=1; realignment to slot 0 still happens in that same beat.
  - FS=1 with SLOT==00 is a legal sync and leaves ERR unchanged.
- ERR is sticky and cleared only by RST.
- Outputs not targeted in a cycle always hold; exactly one STB bit is set per valid beat.
- MODE switching: MODE=0 clears SLOT, so the first MODE=1 beat without FS goes to A. Switching mid-frame discards the partial TDM position and raises no error.
- Reset mid-frame: all state cleared immediately, without waiting for a clock edge. The next valid beat in MODE=1 goes to A.
- No backpressure: the block always accepts a VALID beat.

Test Plan:
- Reset, bench instance WIDTH=4: hold RST=1 for 3 cycles with VALID=1, DIN=F → A–D=0, STB=0, SLOT=0, ERR=0 throughout.
- MODE=0, VALID=1, ({S1,S2},DIN) = (00,1), (01,2), (10,3), (11,4) over 4 cycles:
  - STB sequence 0001, 0010, 0100, 1000, each one cycle after its input.
  - Final A=1, B=2, C=3, D=4; FRAME never high.
- MODE=1, FS=1 on the first beat, DIN=5,6,7,8,9 on consecutive valid beats:
  - A=5, B=6, C=7, D=8; FRAME high only on the cycle after the 4th beat.
  - 5th beat (DIN=9) overwrites A; SLOT shows 1,2,3,0,1; ERR stays 0.
- MODE=1 with VALID toggling 1,0,1,0: SLOT advances only on valid beats; STB=0000 on idle cycles; outputs hold.
- MODE=1, FS=1 at SLOT=2 with DIN=A:
  - A=A and STB=0001; ERR becomes 1 and stays 1 through further aligned frames.
  - ERR clears only after RST pulse.
- Async RST asserted between clock edges mid-frame (SLOT=2): outputs clear before the next edge; the next valid beat lands in A.
